alu_multicycle: RTL and testbench

- Execute stage directly downstream of ALU_Control. Consumes its 4-bit ALU operation code plus the two operands and produces the registered result and zero flag.
- Single-cycle ops (add/sub/or/lui) finish in one cycle.
- Shifts (sll/srl) run iteratively, one bit position per cycle, under a start/done handshake.
- Intended as the ALU for the planned multi-cycle datapath; the stall logic uses busy_o to hold the PC.

---
 rtl/alu_multicycle_if.sv | 24 ++
 rtl/alu_multicycle.sv | 137 +++++++++++++
 tb/tb_alu_multicycle.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Execute-stage request/response bundle for alu_multicycle.
// master drives the operation request; slave is the ALU.
interface alu_multicycle_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start_i;
   logic [3:0]            ALU_Operation_i;
   logic [DATA_WIDTH-1:0] A_i;
   logic [DATA_WIDTH-1:0] B_i;
   logic                  busy_o;
   logic                  done_o;
   logic [DATA_WIDTH-1:0] ALU_Result_o;
   logic                  Zero_o;

   modport master (
      output start_i, ALU_Operation_i, A_i, B_i,
      input  busy_o, done_o, ALU_Result_o, Zero_o
   );

   modport slave (
      input  start_i, ALU_Operation_i, A_i, B_i,
      output busy_o, done_o, ALU_Result_o, Zero_o
   );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: add/sub/or/lui in one cycle, sll/srl iterate one bit per cycle.
// Define ALU_BARREL_SHIFT_EN to compute shifts combinationally with latency 1.
module alu_multicycle #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   alu_multicycle_if.slave  bus
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SRL = 4'b0100;
   localparam logic [3:0] OP_LUI = 4'b0101;

   logic [SHAMT_WIDTH-1:0] shamt;
   logic [DATA_WIDTH-1:0]  alu_1c;
   logic [DATA_WIDTH-1:0]  result_q, result_d;
   logic                   zero_q;
   logic                   done_q, done_d;

   assign shamt = bus.B_i[SHAMT_WIDTH-1:0];

   // Result for every op that completes on the launch edge.
   always_comb begin
      alu_1c = '0;
      unique case (bus.ALU_Operation_i)
         OP_ADD:  alu_1c = bus.A_i + bus.B_i;
         OP_SUB:  alu_1c = bus.A_i - bus.B_i;
         OP_OR:   alu_1c = bus.A_i | bus.B_i;
         OP_LUI:  alu_1c = bus.B_i;
`ifdef ALU_BARREL_SHIFT_EN
         OP_SLL:  alu_1c = bus.A_i << shamt;
         OP_SRL:  alu_1c = bus.A_i >> shamt;
`else
         OP_SLL,
         OP_SRL:  alu_1c = bus.A_i;
`endif
         default: alu_1c = '0;
      endcase
   end

`ifdef ALU_BARREL_SHIFT_EN
   always_comb begin
      result_d = result_q;
      done_d   = 1'b0;
      if (bus.start_i) begin
         result_d = alu_1c;
         done_d   = 1'b1;
      end
   end

   assign bus.busy_o = 1'b0;
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  shreg_q, shreg_d, shreg_nxt;
   logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   left_q, left_d;
   logic                   is_shift;

   assign is_shift  = (bus.ALU_Operation_i == OP_SLL) || (bus.ALU_Operation_i == OP_SRL);
   assign shreg_nxt = left_q ? (shreg_q << 1) : (shreg_q >> 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         left_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      result_d = result_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               if (is_shift && (shamt != '0)) begin
                  state_d = SHIFT;
                  shreg_d = bus.A_i;
                  cnt_d   = shamt;
                  left_d  = (bus.ALU_Operation_i == OP_SLL);
               end else begin
                  result_d = alu_1c;
                  done_d   = 1'b1;
               end
            end
         end
         SHIFT: begin
            shreg_d = shreg_nxt;
            cnt_d   = cnt_q - 1'b1;
            // cnt==1 means this edge performs the last shift position.
            if (cnt_q == SHAMT_WIDTH'(1)) begin
               result_d = shreg_nxt;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy_o = (state_q == SHIFT);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         done_q   <= done_d;
         if (done_d) zero_q <= (result_d == '0);
      end
   end

   assign bus.done_o       = done_q;
   assign bus.ALU_Result_o = result_q;
   assign bus.Zero_o       = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (iterative-shift build): stimulus pushes
// expected result/zero/completion cycle, a negedge monitor pops on done_o.
module tb_alu_multicycle;
   localparam int DW = 32;

   typedef struct {
      logic [DW-1:0] res;
      logic          zero;
      int            due;
      string         name;
   } exp_t;

   logic   clk   = 1'b0;
   logic   reset = 1'b0;
   int     cyc    = 0;
   int     checks = 0;
   int     errors = 0;
   exp_t   sb[$];
   logic [DW-1:0] last_res = '0;

   alu_multicycle_if #(.DATA_WIDTH(DW)) bus ();

   alu_multicycle #(.DATA_WIDTH(DW), .SHAMT_WIDTH(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: result/zero/latency on done_o, and result must hold otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         last_res = '0;
      end else if (bus.done_o) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done result=%h cyc=%0d", bus.ALU_Result_o, cyc);
         end else begin
            e = sb.pop_front();
            if (bus.ALU_Result_o !== e.res || bus.Zero_o !== e.zero || cyc != e.due) begin
               errors++;
               $display("FAIL %s got res=%h zero=%b cyc=%0d exp res=%h zero=%b cyc=%0d",
                        e.name, bus.ALU_Result_o, bus.Zero_o, cyc, e.res, e.zero, e.due);
            end
         end
         last_res = bus.ALU_Result_o;
      end else begin
         checks++;
         if (bus.ALU_Result_o !== last_res) begin
            errors++;
            $display("FAIL result_hold got=%h exp=%h cyc=%0d", bus.ALU_Result_o, last_res, cyc);
         end
      end
   end

   task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   // Drive one request; start is sampled at the next posedge. Returns at the following negedge.
   task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] res, input int lat, input bit expect_done, input string n);
      exp_t e;
      bus.start_i = 1'b1;
      bus.ALU_Operation_i = op;
      bus.A_i = a;
      bus.B_i = b;
      if (expect_done) begin
         e.res = res; e.zero = (res == '0); e.due = cyc + 1 + lat; e.name = n;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      bus.start_i = 1'b0;
      bus.ALU_Operation_i = 4'($urandom);
      bus.A_i = $urandom;
      bus.B_i = $urandom;
   endtask

   // Wait out a shift while hammering start (must be ignored).
   task automatic wait_idle(input string n);
      int k = 0;
      while (bus.busy_o === 1'b1 && k < 100) begin
         bus.start_i = 1'b1;
         bus.ALU_Operation_i = 4'b0000;
         bus.A_i = $urandom;
         bus.B_i = $urandom;
         @(negedge clk);
         k++;
      end
      idle();
      chk({n, "_busy_bound"}, DW'(k >= 100), '0);
   endtask

   initial begin
      idle();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_result", bus.ALU_Result_o, '0);
      chk("rst_zero", DW'(bus.Zero_o), 1);
      chk("rst_busy", DW'(bus.busy_o), 0);
      chk("rst_done", DW'(bus.done_o), 0);

      send(4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, "add_wrap");
      chk("add_busy", DW'(bus.busy_o), 0);
      idle();
      @(negedge clk);

      send(4'b0001, 32'h5, 32'h7, 32'hFFFF_FFFE, 0, 1, "sub_neg");
      send(4'b0010, 32'hF0, 32'h0F, 32'hFF, 0, 1, "or_b2b");
      chk("b2b_done", DW'(bus.done_o), 1);
      idle();
      @(negedge clk);

      send(4'b0011, 32'h1, 32'd31, 32'h8000_0000, 31, 1, "sll_31");
      chk("sll_busy", DW'(bus.busy_o), 1);
      wait_idle("sll_31");
      @(negedge clk);

      send(4'b0100, 32'h8000_0000, 32'd4, 32'h0800_0000, 4, 1, "srl_4");
      chk("srl_busy", DW'(bus.busy_o), 1);
      wait_idle("srl_4");

      send(4'b0011, 32'h1234, 32'h20, 32'h1234, 0, 1, "sll_shamt0");
      chk("shamt0_busy", DW'(bus.busy_o), 0);
      send(4'b1111, 32'h5, 32'h6, 32'h0, 0, 1, "undef_op");
      idle();
      @(negedge clk);

      send(4'b0100, 32'hF0, 32'h21, 32'h78, 1, 1, "srl_1");
      wait_idle("srl_1");
      send(4'b0001, 32'h3, 32'h3, 32'h0, 0, 1, "sub_zero");
      send(4'b0000, 32'h7, 32'h8, 32'hF, 0, 1, "add_small");
      idle();
      repeat (2) @(negedge clk);

      // Abort a long shift with reset around cycle 10 of the operation.
      send(4'b0100, 32'hFFFF_FFFF, 32'd20, 32'h0, 20, 0, "srl_abort");
      idle();
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_busy", DW'(bus.busy_o), 0);
      chk("abort_result", bus.ALU_Result_o, '0);
      chk("abort_zero", DW'(bus.Zero_o), 1);
      chk("abort_done", DW'(bus.done_o), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (25) @(negedge clk);

      send(4'b0101, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 0, 1, "lui");
      idle();
      repeat (3) @(negedge clk);
      chk("sb_drained", DW'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
